// File: rtl/bernoulli_burst_if.sv
// Control/data bundle for bernoulli_burst_array.
// hit_cnt and CNT_W exist only when BERNOULLI_HITCNT_EN is defined.
interface bernoulli_burst_if #(
  parameter int WIDTH     = 16,
  parameter int CMP_WIDTH = 7,
  parameter int OUTPUTS   = 8,
  parameter int LEN_W     = 8
`ifdef BERNOULLI_HITCNT_EN
  , parameter int CNT_W   = 8
`endif
);
  localparam int AW = (OUTPUTS > 1) ? $clog2(OUTPUTS) : 1;

  logic                 en;
  logic                 cfg_we;
  logic [AW-1:0]        cfg_addr;
  logic [CMP_WIDTH-1:0] cfg_data;
  logic                 reseed_we;
  logic [WIDTH-1:0]     reseed_data;
  logic                 start;
  logic [LEN_W-1:0]     burst_len;
  logic                 busy;
  logic [OUTPUTS-1:0]   out;
  logic                 out_valid;
  logic                 done;
`ifdef BERNOULLI_HITCNT_EN
  logic [OUTPUTS*CNT_W-1:0] hit_cnt;
`endif

  modport master (
    output en, cfg_we, cfg_addr, cfg_data, reseed_we, reseed_data, start, burst_len,
`ifdef BERNOULLI_HITCNT_EN
    input  hit_cnt,
`endif
    input  busy, out, out_valid, done
  );

  modport slave (
    input  en, cfg_we, cfg_addr, cfg_data, reseed_we, reseed_data, start, burst_len,
`ifdef BERNOULLI_HITCNT_EN
    output hit_cnt,
`endif
    output busy, out, out_valid, done
  );
endinterface

// File: rtl/bernoulli_burst_array.sv
// Multi-channel Bernoulli spike source: one shared Galois LFSR, per-channel thresholds, bursts.
// Optional per-channel saturating hit counters under macro BERNOULLI_HITCNT_EN.
//
// state | meaning
// IDLE  | waiting for start (with en)
// BURST | emitting one sample per en=1 cycle until remaining hits 0
// DONE  | last cycle of the burst (busy); done pulses on the following cycle
module bernoulli_burst_array #(
  parameter int                   WIDTH     = 16,
  parameter logic [WIDTH-1:0]     POLY      = 16'hB400,
  parameter logic [WIDTH-1:0]     SEED      = 16'hDEAD,
  parameter int                   CMP_WIDTH = 7,
  parameter int                   OUTPUTS   = 8,
  parameter int                   STRIDE    = 3,
  parameter logic [CMP_WIDTH-1:0] INIT_THR  = 7'd32,
  parameter int                   LEN_W     = 8
`ifdef BERNOULLI_HITCNT_EN
  , parameter int                 CNT_W     = 8
`endif
) (
  input logic               clk,
  input logic               rst,
  bernoulli_burst_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;

  state_t               state_q, state_d;
  logic [LEN_W-1:0]     remaining_q, remaining_d;
  logic [WIDTH-1:0]     lfsr_q, lfsr_d;
  logic [OUTPUTS-1:0]   out_q, out_d;
  logic                 out_valid_q, out_valid_d;
  logic                 done_q, done_d;
  logic [CMP_WIDTH-1:0] thr_q [OUTPUTS];
  logic [CMP_WIDTH-1:0] rnd [OUTPUTS];
  logic [OUTPUTS-1:0]   hit;
  logic                 start_accept;

  always_comb begin
    if (bus.reseed_we)
      lfsr_d = (bus.reseed_data == '0) ? WIDTH'(1) : bus.reseed_data;
    else if (bus.en)
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? POLY : '0);
    else
      lfsr_d = lfsr_q;
  end

  // Channel i sees the LFSR rotated right by i*STRIDE, low CMP_WIDTH bits.
  always_comb begin
    hit = '0;
    for (int i = 0; i < OUTPUTS; i++) begin
      rnd[i] = '0;
      for (int k = 0; k < CMP_WIDTH; k++)
        rnd[i][k] = lfsr_q[(k + i * STRIDE) % WIDTH];
      hit[i] = rnd[i] < thr_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < OUTPUTS; i++) thr_q[i] <= INIT_THR;
    end else if (bus.cfg_we && (int'(bus.cfg_addr) < OUTPUTS)) begin
      thr_q[bus.cfg_addr] <= bus.cfg_data;
    end
  end

  assign start_accept = (state_q == IDLE) && bus.start && bus.en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      lfsr_q      <= SEED_EFF;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      lfsr_q      <= lfsr_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_accept) begin
          remaining_d = bus.burst_len;
          state_d     = (bus.burst_len == '0) ? DONE : BURST;
        end
      end
      BURST: begin
        if (bus.en) begin
          out_d       = hit;
          out_valid_d = 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == LEN_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.done      = done_q;

`ifdef BERNOULLI_HITCNT_EN
  logic [CNT_W-1:0] cnt_q [OUTPUTS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < OUTPUTS; i++) cnt_q[i] <= '0;
    end else if (start_accept) begin
      for (int i = 0; i < OUTPUTS; i++) cnt_q[i] <= '0;
    end else if (out_valid_d) begin
      for (int i = 0; i < OUTPUTS; i++)
        if (out_d[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + 1'b1;
    end
  end

  always_comb begin
    bus.hit_cnt = '0;
    for (int i = 0; i < OUTPUTS; i++) bus.hit_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
  end
`endif
endmodule

// File: tb/tb_bernoulli_burst_array.sv
// Randomized bench for bernoulli_burst_array against a cycle-level behavioural model.
module tb_bernoulli_burst_array;
  localparam int N = 8;
  localparam int W = 16;
`ifdef BERNOULLI_HITCNT_EN
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;
`else
  localparam int CMAX = 255;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

`ifdef BERNOULLI_HITCNT_EN
  bernoulli_burst_if #(.WIDTH(16), .CMP_WIDTH(7), .OUTPUTS(8), .LEN_W(8), .CNT_W(CW)) bus ();
  bernoulli_burst_array #(.WIDTH(16), .CMP_WIDTH(7), .OUTPUTS(8), .LEN_W(8), .CNT_W(CW))
    dut (.clk(clk), .rst(rst), .bus(bus));
`else
  bernoulli_burst_if #(.WIDTH(16), .CMP_WIDTH(7), .OUTPUTS(8), .LEN_W(8)) bus ();
  bernoulli_burst_array #(.WIDTH(16), .CMP_WIDTH(7), .OUTPUTS(8), .LEN_W(8))
    dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  logic [10:0] dut_vec;
  assign dut_vec = {bus.busy, bus.done, bus.out_valid, bus.out};

  // behavioural model
  logic [15:0] m_lfsr;
  logic [6:0]  m_thr [N];
  bit          m_busy, m_closing, m_valid, m_done;
  int          m_left;
  logic [7:0]  m_out;
  int          m_cnt [N];

  function automatic logic [10:0] m_vec();
    return {m_busy, m_done, m_valid, m_out};
  endfunction

`ifdef BERNOULLI_HITCNT_EN
  function automatic logic [N*CW-1:0] m_cnt_vec();
    logic [N*CW-1:0] v = '0;
    for (int i = 0; i < N; i++) v[i*CW +: CW] = CW'(m_cnt[i]);
    return v;
  endfunction
`endif

  function automatic void model_reset();
    m_lfsr = 16'hDEAD;
    for (int i = 0; i < N; i++) begin m_thr[i] = 7'd32; m_cnt[i] = 0; end
    m_busy = 0; m_closing = 0; m_valid = 0; m_done = 0; m_left = 0; m_out = '0;
  endfunction

  function automatic void model_edge();
    logic [7:0]  smp = '0;
    logic [31:0] x, rot;
    int r;
    for (int i = 0; i < N; i++) begin
      x   = {16'h0, m_lfsr};
      r   = (i * 3) % W;
      rot = ((x >> r) | (x << (W - r))) & 32'hFFFF;
      smp[i] = (int'(rot[6:0]) < int'(m_thr[i]));
    end
    m_valid = 0;
    m_done  = 0;
    if (m_closing) begin
      m_closing = 0; m_busy = 0; m_done = 1;
    end else if (m_busy) begin
      if (bus.en) begin
        m_out = smp; m_valid = 1;
        for (int i = 0; i < N; i++) if (smp[i] && m_cnt[i] < CMAX) m_cnt[i]++;
        m_left--;
        if (m_left == 0) m_closing = 1;
      end
    end else if (bus.start && bus.en) begin
      m_busy = 1;
      m_left = int'(bus.burst_len);
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      if (m_left == 0) m_closing = 1;
    end
    if (bus.reseed_we) m_lfsr = (bus.reseed_data == 16'h0) ? 16'd1 : bus.reseed_data;
    else if (bus.en)   m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    if (bus.cfg_we && int'(bus.cfg_addr) < N) m_thr[bus.cfg_addr] = bus.cfg_data;
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.en = 1'b1; bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
    bus.reseed_we = 1'b0; bus.reseed_data = '0; bus.start = 1'b0; bus.burst_len = '0;
  endtask

  task automatic cfg_write(input int a, input int d);
    bus.cfg_we = 1'b1; bus.cfg_addr = 3'(a); bus.cfg_data = 7'(d);
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (dut_vec !== 11'h0) begin bad++; $display("FAIL reset_vals: got %h expected %h", dut_vec, 11'h0); end
`ifdef BERNOULLI_HITCNT_EN
    total++;
    if (bus.hit_cnt !== '0) begin bad++; $display("FAIL reset_hitcnt: got %h expected 0", bus.hit_cnt); end
`endif
    rst = 1'b0;
    bus.start = 1'b1; bus.burst_len = 8'd8;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < 11; c++) begin
      total++;
      if (dut_vec !== m_vec()) begin bad++; $display("FAIL reset_burst c%0d: got %h expected %h", c, dut_vec, m_vec()); end
      tick();
    end
  endtask

  task automatic test_thr_extremes();
    int valids = 0, dones = 0, ones0 = 0, ones1 = 0;
    for (int i = 2; i < N; i++) cfg_write(i, $urandom_range(0, 127));
    cfg_write(0, 0);
    cfg_write(1, 127);
    bus.start = 1'b1; bus.burst_len = 8'd200;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < 206; c++) begin
      total++;
      if (dut_vec !== m_vec()) begin bad++; $display("FAIL thr_ext c%0d: got %h expected %h", c, dut_vec, m_vec()); end
      if (bus.out_valid) begin valids++; ones0 += int'(bus.out[0]); ones1 += int'(bus.out[1]); end
      if (bus.done) dones++;
      tick();
    end
    total++;
    if (valids != 200) begin bad++; $display("FAIL thr_ext_valids: got %0d expected 200", valids); end
    total++;
    if (dones != 1) begin bad++; $display("FAIL thr_ext_done: got %0d expected 1", dones); end
    total++;
    if (ones0 != 0) begin bad++; $display("FAIL thr0_never: got %0d expected 0", ones0); end
    total++;
    if (ones1 < 185) begin bad++; $display("FAIL thr127_rate: got %0d expected >=185", ones1); end
  endtask

  task automatic test_len_zero();
    int valids = 0, dones = 0;
    bus.start = 1'b1; bus.burst_len = 8'd0;
    tick();
    bus.start = 1'b0;
    total++;
    if ({bus.busy, bus.done, bus.out_valid} !== 3'b100) begin bad++; $display("FAIL len0_c1: got %b expected 100", {bus.busy, bus.done, bus.out_valid}); end
    tick();
    total++;
    if ({bus.busy, bus.done, bus.out_valid} !== 3'b010) begin bad++; $display("FAIL len0_c2: got %b expected 010", {bus.busy, bus.done, bus.out_valid}); end
    tick();
    total++;
    if (dut_vec !== m_vec() || bus.done !== 1'b0) begin bad++; $display("FAIL len0_c3: got %h expected %h", dut_vec, m_vec()); end
    // second start while busy must be ignored
    bus.start = 1'b1; bus.burst_len = 8'd5;
    tick();
    bus.burst_len = 8'd50;
    for (int c = 0; c < 20; c++) begin
      if (c == 3) bus.start = 1'b0;
      tick();
      total++;
      if (dut_vec !== m_vec()) begin bad++; $display("FAIL busy_start c%0d: got %h expected %h", c, dut_vec, m_vec()); end
      if (bus.out_valid) valids++;
      if (bus.done) dones++;
    end
    total++;
    if (valids != 5 || dones != 1) begin bad++; $display("FAIL busy_start_count: got %0d/%0d expected 5/1", valids, dones); end
  endtask

  task automatic test_en_toggle();
    int valids = 0;
    bit seen_done = 0;
    logic [7:0] prev;
    bus.start = 1'b1; bus.burst_len = 8'd10;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < 300 && !seen_done; c++) begin
      bus.en = 1'($urandom_range(0, 1));
      prev = bus.out;
      tick();
      total++;
      if (dut_vec !== m_vec()) begin bad++; $display("FAIL en_toggle c%0d: got %h expected %h", c, dut_vec, m_vec()); end
      if (bus.en == 1'b0) begin
        total++;
        if (bus.out !== prev || bus.out_valid !== 1'b0) begin bad++; $display("FAIL en_freeze c%0d: got %h/%b expected %h/0", c, bus.out, bus.out_valid, prev); end
      end
      if (bus.out_valid) valids++;
      if (bus.done) seen_done = 1;
    end
    bus.en = 1'b1;
    total++;
    if (valids != 10 || !seen_done) begin bad++; $display("FAIL en_toggle_count: got %0d done=%0d expected 10 done=1", valids, seen_done); end
  endtask

  task automatic test_reseed();
    logic [7:0] seq [2][$];
    logic [15:0] seed;
    bus.reseed_we = 1'b1; bus.reseed_data = 16'h0;
    tick();
    bus.reseed_we = 1'b0;
    total++;
    if (m_lfsr !== 16'h0001) begin bad++; $display("FAIL reseed0_model: got %h expected 0001", m_lfsr); end
    seed = 16'($urandom_range(1, 65535));
    for (int rep = 0; rep < 2; rep++) begin
      bus.reseed_we = 1'b1; bus.reseed_data = (rep == 0) ? 16'h0 : seed;
      tick();
      if (rep == 0) begin
        bus.start = 1'b1; bus.burst_len = 8'd12; bus.reseed_we = 1'b0;
        tick();
        bus.start = 1'b0;
        for (int c = 0; c < 14; c++) begin
          tick();
          total++;
          if (dut_vec !== m_vec()) begin bad++; $display("FAIL reseed0 c%0d: got %h expected %h", c, dut_vec, m_vec()); end
        end
        bus.reseed_we = 1'b1; bus.reseed_data = seed;
        tick();
      end
      bus.reseed_we = 1'b0;
      bus.start = 1'b1; bus.burst_len = 8'd16;
      tick();
      bus.start = 1'b0;
      for (int c = 0; c < 18; c++) begin
        tick();
        total++;
        if (dut_vec !== m_vec()) begin bad++; $display("FAIL reseed_seq r%0d c%0d: got %h expected %h", rep, c, dut_vec, m_vec()); end
        if (bus.out_valid) seq[rep].push_back(bus.out);
      end
    end
    total++;
    if (seq[0].size() != 16 || seq[0] != seq[1]) begin bad++; $display("FAIL reseed_repeat: got sizes %0d/%0d expected identical 16-sample runs", seq[0].size(), seq[1].size()); end
    // threshold write in the same cycle as a sample uses the old threshold
    cfg_write(2, 0);
    bus.start = 1'b1; bus.burst_len = 8'd4;
    tick();
    bus.start = 1'b0;
    bus.cfg_we = 1'b1; bus.cfg_addr = 3'd2; bus.cfg_data = 7'd127;
    tick();
    bus.cfg_we = 1'b0;
    total++;
    if (bus.out_valid !== 1'b1 || bus.out[2] !== 1'b0) begin bad++; $display("FAIL cfg_same_cycle: got valid=%b out2=%b expected 1/0", bus.out_valid, bus.out[2]); end
    for (int c = 0; c < 5; c++) begin
      tick();
      total++;
      if (dut_vec !== m_vec()) begin bad++; $display("FAIL cfg_after c%0d: got %h expected %h", c, dut_vec, m_vec()); end
    end
  endtask

  task automatic test_reset_mid_burst();
    int dones = 0;
    cfg_write(3, 100);
    bus.start = 1'b1; bus.burst_len = 8'd50;
    tick();
    bus.start = 1'b0;
    repeat (10) tick();
    #2 rst = 1'b1;
    #1;
    total++;
    if (dut_vec !== 11'h0) begin bad++; $display("FAIL reset_mid: got %h expected %h", dut_vec, 11'h0); end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (bus.done) dones++;
    end
    total++;
    if (dones != 0) begin bad++; $display("FAIL reset_mid_done: got %0d expected 0", dones); end
    bus.start = 1'b1; bus.burst_len = 8'd30;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < 33; c++) begin
      tick();
      total++;
      if (dut_vec !== m_vec()) begin bad++; $display("FAIL reset_mid_burst c%0d: got %h expected %h", c, dut_vec, m_vec()); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      bus.en          = ($urandom_range(0, 7) != 0);
      bus.cfg_we      = ($urandom_range(0, 5) == 0);
      bus.cfg_addr    = 3'($urandom_range(0, 7));
      bus.cfg_data    = 7'($urandom_range(0, 127));
      bus.reseed_we   = ($urandom_range(0, 49) == 0);
      bus.reseed_data = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      bus.start       = ($urandom_range(0, 9) == 0);
      bus.burst_len   = 8'($urandom_range(0, 11));
      tick();
      total++;
      if (dut_vec !== m_vec()) begin bad++; $display("FAIL random c%0d: got %h expected %h", c, dut_vec, m_vec()); end
`ifdef BERNOULLI_HITCNT_EN
      total++;
      if (bus.hit_cnt !== m_cnt_vec()) begin bad++; $display("FAIL random_hitcnt c%0d: got %h expected %h", c, bus.hit_cnt, m_cnt_vec()); end
`endif
    end
    idle_inputs();
    repeat (20) tick();
  endtask

`ifdef BERNOULLI_HITCNT_EN
  task automatic test_hitcnt();
    for (int i = 0; i < N; i++) cfg_write(i, 127);
    bus.start = 1'b1; bus.burst_len = 8'd100;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < 102; c++) begin
      tick();
      total++;
      if (bus.hit_cnt !== m_cnt_vec()) begin bad++; $display("FAIL hitcnt c%0d: got %h expected %h", c, bus.hit_cnt, m_cnt_vec()); end
    end
    total++;
    if (bus.hit_cnt !== {N{4'hF}}) begin bad++; $display("FAIL hitcnt_sat: got %h expected %h", bus.hit_cnt, {N{4'hF}}); end
    bus.start = 1'b1; bus.burst_len = 8'd3;
    tick();
    bus.start = 1'b0;
    total++;
    if (bus.hit_cnt !== '0) begin bad++; $display("FAIL hitcnt_clear: got %h expected 0", bus.hit_cnt); end
    repeat (6) tick();
  endtask
`endif

  initial begin
    test_reset();
    test_thr_extremes();
    test_len_zero();
    test_en_toggle();
    test_reseed();
    test_reset_mid_burst();
`ifdef BERNOULLI_HITCNT_EN
    test_hitcnt();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
